// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD sequencer and its lane arithmetic units.
package simd_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int DATA_W = LANES * LANE_W;

  // Command mode: which arithmetic unit drives the write-back data.
  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_SCA = 1'b1;

  // Vector-unit op codes (a op b, per lane).
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  // Scalar-unit op codes (a op const, per lane). OP_MUL is shared.
  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_THR  = 2'd1;
  localparam logic [1:0] OP_CMP  = 2'd2;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/simd_scalar.sv
// Element-wise vector-versus-constant op over four 16-bit lanes (unsigned compares).
module simd_scalar
  import simd_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [LANE_W-1:0] c_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] y_o
);

  logic [LANE_W-1:0] la;
  logic [LANE_W-1:0] lr;

  // Per-lane arithmetic against the broadcast constant.
  always_comb begin
    y_o = '0;
    la  = '0;
    lr  = '0;
    for (int l = 0; l < LANES; l++) begin
      la = a_i[l*LANE_W +: LANE_W];
      unique case (op_i)
        OP_PASS: lr = la;
        OP_THR:  lr = (la > c_i) ? la : c_i;
        OP_CMP:  lr = (la > c_i) ? LANE_W'(1) : '0;
        OP_MUL:  lr = la * c_i;
        default: lr = '0;
      endcase
      y_o[l*LANE_W +: LANE_W] = lr;
    end
  end

endmodule

// File: rtl/simd_vector.sv
// Element-wise vector op over four 16-bit lanes; all results wrap at 16 bits.
module simd_vector
  import simd_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] y_o
);

  logic [LANE_W-1:0] la;
  logic [LANE_W-1:0] lb;
  logic [LANE_W-1:0] lr;

  // Per-lane arithmetic selected by the op code.
  always_comb begin
    y_o = '0;
    la  = '0;
    lb  = '0;
    lr  = '0;
    for (int l = 0; l < LANES; l++) begin
      la = a_i[l*LANE_W +: LANE_W];
      lb = b_i[l*LANE_W +: LANE_W];
      unique case (op_i)
        OP_NOP:  lr = '0;
        OP_ADD:  lr = la + lb;
        OP_SUB:  lr = la - lb;
        OP_MUL:  lr = la * lb;
        default: lr = '0;
      endcase
      y_o[l*LANE_W +: LANE_W] = lr;
    end
  end

endmodule

// File: rtl/simd_ctrl.sv
// Command sequencer: streams a run of buffer words through the vector or
// scalar unit and writes results back two cycles after each read.
//
//   state    | meaning
//   ST_IDLE  | ready for a command; zero-length commands finish here
//   ST_RUN   | issuing reads, one per unpaused cycle
//   ST_DRAIN | all reads issued, waiting for the last write to go out
module simd_ctrl
  import simd_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [15:0]       cmd_const,
  input  logic              pause,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [63:0]       rd_data_a,
  input  logic [63:0]       rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic              mode_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [15:0]       const_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              done_q;

  // Read-to-write pipeline: stage 1 holds the read just issued, stage 2 the write.
  logic              v1_q;
  logic [ADDR_W-1:0] wa1_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              cmd_fire;
  logic              issue;
  logic              last_rd;
  logic [ADDR_W-1:0] cnt_addr;
  logic [DATA_W-1:0] vec_y;
  logic [DATA_W-1:0] sca_y;
  logic [DATA_W-1:0] wr_data_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Pause acts in the same cycle so a paused cycle never issues a read.
  assign issue     = (state_q == ST_RUN) & ~pause;
  assign last_rd   = (cnt_q == (len_q - LEN_W'(1)));
  assign cnt_addr  = cnt_q[ADDR_W-1:0];

  assign rd_en     = issue;
  assign rd_addr_a = src_a_q + cnt_addr;
  assign rd_addr_b = (mode_q == MODE_SCA) ? '0 : (src_b_q + cnt_addr);

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  simd_vector u_vec (
    .a_i  (rd_data_a),
    .b_i  (rd_data_b),
    .op_i (op_q),
    .y_o  (vec_y)
  );

  simd_scalar u_sca (
    .a_i  (rd_data_a),
    .c_i  (const_q),
    .op_i (op_q),
    .y_o  (sca_y)
  );

  // Mode mux on the unit outputs feeding the write-data register.
  always_comb begin
    wr_data_d = vec_y;
    if (mode_q == MODE_SCA) begin
      wr_data_d = sca_y;
    end
  end

  // Command latch, element counter and state sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_VEC;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      const_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            mode_q  <= cmd_mode;
            op_q    <= cmd_op;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
            len_q   <= cmd_len;
            const_q <= cmd_const;
            cnt_q   <= '0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last_rd) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // No read in stage 1 means the write now on the port is the last one.
          if (!v1_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Two-stage valid/address pipeline; result is registered as it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      wa1_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      v1_q    <= issue;
      wr_en_q <= v1_q;
      if (issue) begin
        wa1_q <= dst_q + cnt_addr;
      end
      if (v1_q) begin
        wr_addr_q <= wa1_q;
        wr_data_q <= wr_data_d;
      end
    end
  end

endmodule

// File: tb/tb_simd_ctrl.sv
// Directed bench for simd_ctrl with a simple two-read/one-write buffer model.
module tb_simd_ctrl;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_src_a = '0;
  logic [9:0]  cmd_src_b = '0;
  logic [9:0]  cmd_dst = '0;
  logic [10:0] cmd_len = '0;
  logic [15:0] cmd_const = '0;
  logic        pause = 1'b0;
  logic        rd_en;
  logic [9:0]  rd_addr_a;
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_a = '0;
  logic [63:0] rd_data_b = '0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  simd_ctrl #(.ADDR_W(10), .LEN_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_op    (cmd_op),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_const (cmd_const),
    .pause     (pause),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  // Buffer model: registered reads, writes from the DUT, preload from the bench.
  logic [63:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Per-cycle observation log, index = cycles after the accepting edge.
  logic        l_rd   [0:31];
  logic        l_wr   [0:31];
  logic        l_busy [0:31];
  logic        l_done [0:31];
  logic        l_rdy  [0:31];
  logic [9:0]  l_rda  [0:31];
  logic [9:0]  l_rdb  [0:31];
  logic [9:0]  l_wra  [0:31];
  logic [63:0] l_wrd  [0:31];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [63:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1;
    ld_en   = 1'b0;
  endtask

  task automatic run_cmd(input logic mode, input logic [1:0] op,
                         input logic [9:0] sa, input logic [9:0] sb, input logic [9:0] dst,
                         input logic [10:0] len, input logic [15:0] cst,
                         input int ncyc, input int p_start, input int p_len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_op    = op;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_const = cst;
    @(posedge clk);
    #1;
    // Scramble the command fields so any late sampling shows up.
    cmd_valid = 1'b0;
    cmd_mode  = ~mode;
    cmd_op    = ~op;
    cmd_src_a = 10'h155;
    cmd_src_b = 10'h2AA;
    cmd_dst   = 10'h3F0;
    cmd_len   = 11'd5;
    cmd_const = 16'h7777;
    for (int k = 1; k <= ncyc; k++) begin
      pause = (k >= p_start) && (k < p_start + p_len);
      @(negedge clk);
      l_rd[k]   = rd_en;
      l_wr[k]   = wr_en;
      l_busy[k] = busy;
      l_done[k] = done;
      l_rdy[k]  = cmd_ready;
      l_rda[k]  = rd_addr_a;
      l_rdb[k]  = rd_addr_b;
      l_wra[k]  = wr_addr;
      l_wrd[k]  = wr_data;
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
  endtask

  logic [63:0] sca_exp [0:3];
  logic        seen;

  initial begin
    sca_exp[0] = 64'h0004_0003_0002_0001;
    sca_exp[1] = 64'h0004_0003_0002_0002;
    sca_exp[2] = 64'h0001_0001_0000_0000;
    sca_exp[3] = 64'h0008_0006_0004_0002;

    // Preload under reset; lane 0 is the low 16 bits.
    poke(10'd0,    64'h0004_0003_0002_0001);
    poke(10'd8,    64'h0008_0007_0006_0005);
    poke(10'd1,    64'h0000_0000_0000_0009);
    poke(10'd300,  64'hDEAD_BEEF_0000_1111);
    for (int j = 0; j < 4; j++) begin
      poke(10'(32 + j), 64'h0001_0001_0001_0001 * 64'(j + 1));
      poke(10'(40 + j), 64'h0010_0010_0010_0010 * 64'(j + 1));
    end
    poke(10'd1022, 64'h0000_0000_0000_0003);
    poke(10'd1023, 64'h0000_0000_0000_0004);

    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_rdaddr", {rd_addr_a, rd_addr_b}, 0);
    check("rst_wr_bus", {wr_addr, wr_data}, 0);
    rst_n = 1'b1;

    // Vector add, N=1.
    run_cmd(MODE_VEC, OP_ADD, 10'd0, 10'd8, 10'd16, 11'd1, 16'd0, 5, 0, 0);
    check("add_rd1",     l_rd[1], 1);
    check("add_rda1",    l_rda[1], 0);
    check("add_rdb1",    l_rdb[1], 8);
    check("add_rd2",     l_rd[2], 0);
    check("add_wr2",     l_wr[2], 0);
    check("add_wr3",     l_wr[3], 1);
    check("add_wra3",    l_wra[3], 16);
    check("add_wrd3",    l_wrd[3], 64'h000C_000A_0008_0006);
    check("add_busy3",   l_busy[3], 1);
    check("add_done3",   l_done[3], 0);
    check("add_done4",   l_done[4], 1);
    check("add_rdy4",    l_rdy[4], 1);
    check("add_busy4",   l_busy[4], 0);
    check("add_mem16",   mem[16], 64'h000C_000A_0008_0006);

    // Vector sub and mul.
    run_cmd(MODE_VEC, OP_SUB, 10'd0, 10'd8, 10'd17, 11'd1, 16'd0, 5, 0, 0);
    check("sub_wrd3",    l_wrd[3], 64'hFFFC_FFFC_FFFC_FFFC);
    check("sub_mem17",   mem[17], 64'hFFFC_FFFC_FFFC_FFFC);
    run_cmd(MODE_VEC, OP_MUL, 10'd0, 10'd8, 10'd18, 11'd1, 16'd0, 5, 0, 0);
    check("mul_wrd3",    l_wrd[3], 64'h0020_0015_000C_0005);
    check("mul_done4",   l_done[4], 1);

    // Scalar ops with const 2; src_b is nonzero but the port must stay 0.
    for (int op = 0; op < 4; op++) begin
      run_cmd(MODE_SCA, 2'(op), 10'd0, 10'd8, 10'(20 + op), 11'd1, 16'd2, 5, 0, 0);
      check($sformatf("sca%0d_rdb1", op), l_rdb[1], 0);
      check($sformatf("sca%0d_wrd3", op), l_wrd[3], sca_exp[op]);
      check($sformatf("sca%0d_mem", op),  mem[20 + op], sca_exp[op]);
      check($sformatf("sca%0d_done4", op), l_done[4], 1);
    end

    // In-place add, N=4, pause in cycles 3 and 4.
    run_cmd(MODE_VEC, OP_ADD, 10'd32, 10'd40, 10'd32, 11'd4, 16'd0, 11, 3, 2);
    check("ip_rd_pat",
          {l_rd[1], l_rd[2], l_rd[3], l_rd[4], l_rd[5], l_rd[6], l_rd[7]}, 7'b1100110);
    check("ip_wr_pat",
          {l_wr[2], l_wr[3], l_wr[4], l_wr[5], l_wr[6], l_wr[7], l_wr[8], l_wr[9]}, 8'b01100110);
    check("ip_rda5",     l_rda[5], 34);
    check("ip_wra3",     l_wra[3], 32);
    check("ip_wra8",     l_wra[8], 35);
    check("ip_busy8",    l_busy[8], 1);
    check("ip_done8",    l_done[8], 0);
    check("ip_done9",    l_done[9], 1);
    check("ip_mem32",    mem[32], 64'h0011_0011_0011_0011);
    check("ip_mem33",    mem[33], 64'h0022_0022_0022_0022);
    check("ip_mem34",    mem[34], 64'h0033_0033_0033_0033);
    check("ip_mem35",    mem[35], 64'h0044_0044_0044_0044);

    // Address wrap: reads 1022, 1023, 0, 1.
    run_cmd(MODE_VEC, OP_ADD, 10'd1022, 10'd100, 10'd200, 11'd4, 16'd0, 8, 0, 0);
    check("wrap_rda1",   l_rda[1], 1022);
    check("wrap_rda2",   l_rda[2], 1023);
    check("wrap_rda3",   l_rda[3], 0);
    check("wrap_rda4",   l_rda[4], 1);
    check("wrap_done7",  l_done[7], 1);

    // Zero-length command.
    run_cmd(MODE_VEC, OP_ADD, 10'd0, 10'd8, 10'd400, 11'd0, 16'd0, 3, 0, 0);
    check("n0_done1",    l_done[1], 1);
    check("n0_done2",    l_done[2], 0);
    check("n0_quiet",
          {l_rd[1], l_rd[2], l_rd[3], l_wr[1], l_wr[2], l_wr[3], l_busy[1], l_busy[2], l_busy[3]}, 0);

    // Abort an N=8 command during RUN with an asynchronous reset.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = MODE_VEC;
    cmd_op    = OP_ADD;
    cmd_src_a = 10'd48;
    cmd_src_b = 10'd56;
    cmd_dst   = 10'd300;
    cmd_len   = 11'd8;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ab_rd_pre",   rd_en, 1);
    check("ab_rda_pre",  rd_addr_a, 49);
    rst_n = 1'b0;
    #1;
    check("ab_rd_en",    rd_en, 0);
    check("ab_busy",     busy, 0);
    check("ab_ready",    cmd_ready, 1);
    check("ab_rdaddr",   {rd_addr_a, rd_addr_b}, 0);
    check("ab_wr_bus",   {wr_en, wr_addr, wr_data, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || wr_en || busy) seen = 1'b1;
    end
    check("ab_quiet",    seen, 0);
    check("ab_mem300",   mem[300], 64'hDEAD_BEEF_0000_1111);

    run_cmd(MODE_VEC, OP_ADD, 10'd0, 10'd8, 10'd19, 11'd1, 16'd0, 5, 0, 0);
    check("post_done4",  l_done[4], 1);
    check("post_mem19",  mem[19], 64'h000C_000A_0008_0006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/simd_ctrl.md
# simd_ctrl

Command-driven sequencer for the SIMD datapath. It accepts one command describing an element-wise operation over a run of 64-bit words (4 × 16-bit lanes) in the local vector buffer. It streams operands out of the buffer through `simd_vector` (vector⊕vector) or `simd_scalar` (vector⊕constant) and writes results back. It sits between the host command interface and the buffer's two read ports and one write port.

## Interface
Parameters:
- `ADDR_W`, 10: buffer word-address width.
- `LEN_W`, `ADDR_W+1`: element-count width, so a full-buffer run is representable.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_mode` in 1: 0 = vector (`simd_vector`), 1 = scalar (`simd_scalar`).
- `cmd_op` in 2: op code passed to the selected unit.
- `cmd_src_a`, `cmd_src_b`, `cmd_dst` in `ADDR_W`: base word addresses.
- `cmd_len` in `LEN_W`: number of words to process.
- `cmd_const` in 16: scalar operand; scalar mode only.
- `pause` in 1: suppresses issue of new reads.
- `rd_en` out 1: read strobe for both read ports.
- `rd_addr_a`, `rd_addr_b` out `ADDR_W`: read addresses.
- `rd_data_a`, `rd_data_b` in 64: read data, valid the cycle after `rd_en`.
- `wr_en` out 1: write strobe.
- `wr_addr` out `ADDR_W`: write address.
- `wr_data` out 64: write data.
- `busy` out 1: a command is in flight.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch all `cmd_*` fields. Later changes on the inputs are ignored.
  - If `cmd_len`=0, stay in IDLE, pulse `done` next cycle, do no memory access and keep `busy` low.
  - Otherwise go to RUN.
- **RUN**
  - Each cycle with `pause`=0, issue read i: `rd_en`=1, `rd_addr_a`=src_a+i, `rd_addr_b`=src_b+i. Then increment i.
  - With `pause`=1, `rd_en`=0 and i holds.
  - After read len-1 is issued, go to DRAIN.
- **DRAIN**
  - No reads.
  - Leave once the last write has been issued. That cycle returns the FSM to IDLE and `done` pulses in the following cycle.
- Datapath, cycle after a read:
  - `rd_data_a`/`rd_data_b` feed the selected unit with the latched op and constant.
  - The unit output is registered into `wr_data`, with `wr_addr`=dst+i and `wr_en`=1 on the next cycle.
  - A bubble from `pause` propagates as `wr_en`=0.
- Scalar mode: `rd_addr_b` is held 0 and `rd_data_b` is ignored.
- All address arithmetic wraps modulo 2^`ADDR_W`.
- In-place operation (dst = src_a or dst = src_b) is legal. A write to word i always follows the read of word i.
- Lane arithmetic is exactly that of the instantiated units, 16-bit wrap:
  - Vector mode: 0 → zero, 1 → a+b, 2 → a−b, 3 → a·b (low 16 bits).
  - Scalar mode: 0 → a, 1 → max(a,c), 2 → (a>c ? 1 : 0), 3 → a·c (low 16 bits).
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `cmd_ready`=1, and `rd_en`, `wr_en`, `busy`, `done`=0. All address and data outputs are 0.
- Command accepted at edge 0, no pause:
  - `rd_en` high in cycles 1..N.
  - `wr_en` high in cycles 3..N+2.
  - `busy` high in cycles 1..N+2.
  - `done` high in cycle N+3, with `cmd_ready`=1 again in that cycle.
- Read-to-write latency is 2 cycles per element.
- A pause of P cycles during RUN delays every subsequent read, write and `done` by P.
- `pause` during DRAIN or IDLE has no effect.
- A new command may be accepted in the `done` cycle.
- `rst_n` low mid-command aborts immediately:
  - Outputs go to reset values.
  - In-flight writes are dropped and no `done` is produced.

## Structure
- Shared package `simd_pkg`:
  - `LANES`=4, `LANE_W`=16, `DATA_W`=64.
  - Mode encodings `MODE_VEC`/`MODE_SCA`.
  - Op encodings `OP_NOP`/`OP_ADD`/`OP_SUB`/`OP_MUL` (vector) and `OP_PASS`/`OP_THR`/`OP_CMP`/`OP_MUL` (scalar).
  - FSM state typedef.
- Sub-modules: instantiate the existing `simd_vector` and `simd_scalar`, with a mode mux on their outputs.
- No new sub-module; the address counter and pipeline valid/address shift registers live in `simd_ctrl`.

## Test plan
- Vector add, N=1, buf[0]={1,2,3,4}, buf[8]={5,6,7,8}, dst=16 -> buf[16]={6,8,10,12} written in cycle 3, `done` in cycle 4.
- Vector sub and mul, same operands -> {−4,−4,−4,−4} (0xFFFC each) and {5,12,21,32}.
- Scalar ops 0..3 with const 2 on {1,2,3,4} -> {1,2,3,4}, {2,2,3,4}, {0,0,1,1}, {2,4,6,8}; `rd_addr_b` stays 0.
- N=4 in-place add (dst=src_a) with `pause` high for 2 cycles after the second read -> correct results, writes contiguous except a 2-cycle gap, `done` in cycle 9.
- src_a=2^`ADDR_W`−2, N=4 -> reads wrap to addresses 0 and 1; N=0 command -> `done` in cycle 1, no `rd_en`/`wr_en`, `busy` stays low.
- `rst_n` low during RUN of an N=8 command -> outputs at reset values immediately, no `done`, and a subsequent command completes normally.
